note_recorder: RTL and testbench

Capture-and-replay sequencer for the note stream. In record mode it stores each single-cycle hit (octave, note, length) into an internal buffer. In play mode it reads the buffer back in order and drives the sound engine's start/over handshake, one note at a time. It sits between the key/hit front-end and the sound engine, as the consumer and reader of the note stream that free-play produces.

---
 rtl/note_recorder_pkg.sv | 28 ++
 rtl/note_recorder_if.sv | 21 ++
 rtl/note_buffer.sv | 27 ++
 rtl/note_recorder.sv | 160 ++++++++++++++++
 tb/tb_note_recorder.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_recorder_pkg.sv
// Shared widths, buffer geometry defaults and FSM encoding for the note recorder.
package note_recorder_pkg;

    localparam int OCTAVE_BITS   = 3;
    localparam int NOTE_BITS     = 4;
    localparam int LENGTH_BITS   = 4;
    localparam int ENTRY_BITS    = OCTAVE_BITS + NOTE_BITS + LENGTH_BITS;

    localparam int REC_DEPTH     = 64;
    localparam int REC_ADDR_BITS = 6;

    typedef enum logic [2:0] {
        RS_IDLE      = 3'd0,
        RS_REC       = 3'd1,
        RS_ISSUE     = 3'd2,
        RS_WAIT_ACK  = 3'd3,
        RS_WAIT_DONE = 3'd4,
        RS_GAP       = 3'd5
    } rec_state_t;

    // One stored hit; field order is the packed buffer word layout.
    typedef struct packed {
        logic [OCTAVE_BITS-1:0] octave;
        logic [NOTE_BITS-1:0]   note;
        logic [LENGTH_BITS-1:0] length;
    } note_entry_t;

endpackage

// File: rtl/note_recorder_if.sv
// Start/over handshake and note payload between the recorder and the sound engine.
interface note_recorder_if;
    import note_recorder_pkg::*;

    logic                   sd_start;
    logic [OCTAVE_BITS-1:0] sd_octave;
    logic [NOTE_BITS-1:0]   sd_note;
    logic [LENGTH_BITS-1:0] sd_length;
    logic                   sd_over;

    modport master (
        output sd_start, sd_octave, sd_note, sd_length,
        input  sd_over
    );

    modport slave (
        input  sd_start, sd_octave, sd_note, sd_length,
        output sd_over
    );

endinterface

// File: rtl/note_buffer.sv
// Note register file: synchronous write, combinational read, contents not reset.
module note_buffer
    import note_recorder_pkg::*;
#(
    parameter int DEPTH     = REC_DEPTH,
    parameter int ADDR_BITS = REC_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  note_entry_t          wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output note_entry_t          rd_data
);

    note_entry_t mem [DEPTH];

    // Store one hit per write strobe.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/note_recorder.sv
// Capture-and-replay sequencer: records hits into note_buffer, replays them
// through the sound engine's start/over handshake with a silent gap between notes.
module note_recorder
    import note_recorder_pkg::*;
#(
    parameter int DEPTH      = REC_DEPTH,
    parameter int ADDR_BITS  = REC_ADDR_BITS,
    parameter int GAP_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rec_en,
    input  logic                   play_start,
    input  logic                   play_stop,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [OCTAVE_BITS-1:0] in_octave,
    input  logic [NOTE_BITS-1:0]   in_note,
    input  logic [LENGTH_BITS-1:0] in_length,
    note_recorder_if.master        sd,
    output logic [ADDR_BITS:0]     count,
    output logic                   full,
    output logic                   playing,
    output logic [ADDR_BITS-1:0]   play_idx
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] CNT_ONE   = (ADDR_BITS + 1)'(1);

    rec_state_t           state, state_next;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 in_replay;
    logic                 last_note;
    logic                 gap_done;
    logic                 wr_en;
    logic                 sd_start_c;
    logic [ADDR_BITS-1:0] rd_addr;
    note_entry_t          wr_entry;
    note_entry_t          rd_entry;
    note_entry_t          sd_entry;

    assign in_replay = (state == RS_ISSUE) || (state == RS_WAIT_ACK) ||
                       (state == RS_WAIT_DONE) || (state == RS_GAP);
    assign last_note = ({1'b0, play_idx} == (count - CNT_ONE));
    assign gap_done  = (gap_cnt == '0);
    assign full      = (count == DEPTH_CNT);
    // clear beats a simultaneous hit; hits arriving while full are dropped.
    assign wr_en     = (state == RS_REC) && in_valid && !clear && !full;
    assign wr_entry  = {in_octave, in_note, in_length};
    // The only ways into ISSUE are IDLE (entry 0) and GAP (next entry).
    assign rd_addr   = (state == RS_GAP) ? play_idx + 1'b1 : '0;

    assign sd.sd_start  = sd_start_c;
    assign sd.sd_octave = sd_entry.octave;
    assign sd.sd_note   = sd_entry.note;
    assign sd.sd_length = sd_entry.length;

    note_buffer #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (count[ADDR_BITS-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_addr),
        .rd_data (rd_entry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; play_stop overrides every replay transition.
    always_comb begin
        state_next = state;
        case (state)
            RS_IDLE: begin
                if (rec_en) begin
                    state_next = RS_REC;
                end else if (play_start && (count != '0)) begin
                    state_next = RS_ISSUE;
                end
            end
            RS_REC: begin
                if (!rec_en) begin
                    state_next = RS_IDLE;
                end
            end
            RS_ISSUE:     state_next = RS_WAIT_ACK;
            RS_WAIT_ACK: begin
                if (!sd.sd_over) begin
                    state_next = RS_WAIT_DONE;
                end
            end
            RS_WAIT_DONE: begin
                if (sd.sd_over) begin
                    state_next = RS_GAP;
                end
            end
            RS_GAP: begin
                if (gap_done) begin
                    state_next = last_note ? RS_IDLE : RS_ISSUE;
                end
            end
            default:      state_next = RS_IDLE;
        endcase
        if (in_replay && play_stop) begin
            state_next = RS_IDLE;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        sd_start_c = (state == RS_ISSUE);
        playing    = in_replay;
    end

    // Entry counter: advances on each accepted hit, cleared outside replay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (((state == RS_IDLE) || (state == RS_REC)) && clear) begin
            count <= '0;
        end else if (wr_en) begin
            count <= count + CNT_ONE;
        end
    end

    // Replay bookkeeping: note payload latch, entry index and gap countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_entry <= '0;
            play_idx <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state_next == RS_ISSUE) begin
                sd_entry <= rd_entry;
            end
            if (in_replay && (state_next == RS_IDLE)) begin
                play_idx <= '0;
            end else if ((state == RS_GAP) && (state_next == RS_ISSUE)) begin
                play_idx <= play_idx + 1'b1;
            end
            if ((state == RS_WAIT_DONE) && sd.sd_over) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == RS_GAP) && !gap_done) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with a queue-based replay model and a
// behavioural sound engine answering the start/over handshake.
module tb_note_recorder;
    import note_recorder_pkg::*;

    localparam int DEPTH     = 64;
    localparam int ADDR_BITS = 6;
    localparam int GAP       = 16;
    localparam int ACK       = 2;
    localparam int DUR       = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   rec_en = 1'b0;
    logic                   play_start = 1'b0;
    logic                   play_stop = 1'b0;
    logic                   clear = 1'b0;
    logic                   in_valid = 1'b0;
    logic [OCTAVE_BITS-1:0] in_octave = '0;
    logic [NOTE_BITS-1:0]   in_note = '0;
    logic [LENGTH_BITS-1:0] in_length = '0;
    logic [ADDR_BITS:0]     count;
    logic                   full;
    logic                   playing;
    logic [ADDR_BITS-1:0]   play_idx;

    note_recorder_if sd_bus ();

    note_recorder #(
        .DEPTH      (DEPTH),
        .ADDR_BITS  (ADDR_BITS),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rec_en     (rec_en),
        .play_start (play_start),
        .play_stop  (play_stop),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_octave  (in_octave),
        .in_note    (in_note),
        .in_length  (in_length),
        .sd         (sd_bus),
        .count      (count),
        .full       (full),
        .playing    (playing),
        .play_idx   (play_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int oct;
        int note;
        int len;
    } note_t;

    note_t model_buf [DEPTH];
    note_t exp_q [$];
    int    model_count = 0;
    int    passed = 0;
    int    total = 0;
    int    issued = 0;
    int    cyc = 0;
    int    last_rise = 0;
    bit    model_rec = 1'b0;
    bit    model_playing = 1'b0;
    bit    first_note = 1'b0;
    bit    tail_pending = 1'b0;
    bit    rise_seen = 1'b0;
    bit    started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Sound engine: acknowledge a start after ACK cycles, sound for DUR cycles.
    initial begin
        sd_bus.sd_over = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && sd_bus.sd_start === 1'b1) begin
                repeat (ACK) @(posedge clk);
                #1 sd_bus.sd_over = 1'b0;
                repeat (DUR) @(posedge clk);
                #1 sd_bus.sd_over = 1'b1;
                last_rise = cyc;
                rise_seen = 1'b1;
            end
        end
    end

    // Compare process: counters every cycle, replayed notes against the expected queue.
    always @(negedge clk) begin
        if (started && rst_n) begin
            note_t e;
            check("count", count, model_count);
            check("full", full, (model_count == DEPTH));
            if (sd_bus.sd_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("sd_start_unexpected", sd_bus.sd_start, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sd_octave", sd_bus.sd_octave, e.oct);
                    check("sd_note", sd_bus.sd_note, e.note);
                    check("sd_length", sd_bus.sd_length, e.len);
                    if (!first_note) check("gap_timing", cyc, last_rise + GAP + 1);
                    first_note = 1'b0;
                    issued++;
                    rise_seen = 1'b0;
                    if (exp_q.size() == 0) tail_pending = 1'b1;
                end
            end
            if (tail_pending && rise_seen) begin
                if (cyc == last_rise + GAP) begin
                    check("playing_last_gap", playing, 1);
                end else if (cyc == last_rise + GAP + 1) begin
                    check("playing_fall", playing, 0);
                    tail_pending = 1'b0;
                end
            end
        end
    end

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic set_rec(input bit v);
        rec_en = v;
        @(posedge clk); #1;
        model_rec = v;
    endtask

    task automatic hit(input int o, input int n, input int l);
        in_valid  = 1'b1;
        in_octave = OCTAVE_BITS'(o);
        in_note   = NOTE_BITS'(n);
        in_length = LENGTH_BITS'(l);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (model_rec && model_count < DEPTH) begin
            model_buf[model_count] = '{o, n, l};
            model_count++;
        end
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        if (!model_playing) model_count = 0;
    endtask

    task automatic play();
        bit acc;
        acc = (model_count > 0) && !model_rec && !model_playing;
        play_start = 1'b1;
        if (acc) begin
            exp_q.delete();
            for (int i = 0; i < model_count; i++) exp_q.push_back(model_buf[i]);
            first_note    = 1'b1;
            tail_pending  = 1'b0;
            model_playing = 1'b1;
        end
        @(posedge clk); #1;
        play_start = 1'b0;
        @(negedge clk);
        check("playing_after_start", playing, acc);
        check("sd_start_after_start", sd_bus.sd_start, acc);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (playing !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("replay_finished", playing, 0);
        check("all_notes_issued", exp_q.size(), 0);
        model_playing = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_playing", playing, 0);
        check("rst_play_idx", play_idx, 0);
        check("rst_sd_start", sd_bus.sd_start, 0);
        check("rst_sd_octave", sd_bus.sd_octave, 0);
        rst_n = 1'b1;
        started = 1'b1;
        @(posedge clk); #1;

        // Three notes recorded and replayed in order
        set_rec(1);
        hit(1, 2, 3);
        hit(2, 5, 1);
        hit(0, 7, 4);
        set_rec(0);
        check("three_count", count, 3);
        base = issued;
        play();
        check("first_octave", sd_bus.sd_octave, 1);
        check("first_note", sd_bus.sd_note, 2);
        check("first_length", sd_bus.sd_length, 3);
        check("first_idx", play_idx, 0);
        wait_done(400);
        check("three_issued", issued - base, 3);
        check("idx_after_replay", play_idx, 0);

        // Overfill: 65 hits into 64 entries, then replay all of them
        set_rec(1);
        clear_pulse();
        for (int i = 0; i < 65; i++) hit(i % 8, i % 16, (i * 3) % 16);
        check("overfill_count", count, 64);
        check("overfill_full", full, 1);
        set_rec(0);
        base = issued;
        play();
        wait_done(3000);
        check("overfill_issued", issued - base, 64);

        // play_start ignored when empty and while recording
        set_rec(1);
        clear_pulse();
        set_rec(0);
        play();
        set_rec(1);
        hit(4, 4, 4);
        play();
        set_rec(0);
        repeat (30) @(posedge clk);
        #1;
        check("ignored_playing", playing, 0);

        // play_stop during WAIT_DONE of the second note
        set_rec(1);
        clear_pulse();
        hit(3, 1, 2);
        hit(5, 9, 7);
        hit(6, 11, 15);
        set_rec(0);
        base = issued;
        play();
        n = 0;
        while (!(issued == base + 2 && sd_bus.sd_over === 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("stop_reached_note2", (n < 500), 1);
        @(posedge clk); #1;
        check("stop_idx_before", play_idx, 1);
        play_stop = 1'b1;
        exp_q.delete();
        tail_pending = 1'b0;
        model_playing = 1'b0;
        @(posedge clk); #1;
        play_stop = 1'b0;
        @(negedge clk);
        check("stop_playing", playing, 0);
        check("stop_idx", play_idx, 0);
        repeat (60) @(posedge clk);
        #1;
        check("stop_no_more", issued - base, 2);

        // Reset while sd_start is high
        set_rec(1);
        clear_pulse();
        hit(3, 9, 2);
        hit(1, 1, 1);
        set_rec(0);
        play_start = 1'b1;
        exp_q.delete();
        exp_q.push_back(model_buf[0]);
        exp_q.push_back(model_buf[1]);
        first_note = 1'b1;
        model_playing = 1'b1;
        @(posedge clk); #1;
        play_start = 1'b0;
        @(negedge clk);
        check("pre_reset_sd_start", sd_bus.sd_start, 1);
        #1 rst_n = 1'b0;
        model_count = 0;
        exp_q.delete();
        tail_pending = 1'b0;
        model_playing = 1'b0;
        #1;
        check("areset_sd_start", sd_bus.sd_start, 0);
        check("areset_sd_octave", sd_bus.sd_octave, 0);
        check("areset_sd_note", sd_bus.sd_note, 0);
        check("areset_sd_length", sd_bus.sd_length, 0);
        check("areset_count", count, 0);
        check("areset_full", full, 0);
        check("areset_playing", playing, 0);
        check("areset_play_idx", play_idx, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        play();
        check("post_reset_count", count, 0);
        repeat (20) @(posedge clk);
        #1;

        // clear and in_valid together in REC with five entries
        set_rec(1);
        for (int i = 0; i < 5; i++) hit(i, i + 1, i + 2);
        check("five_count", count, 5);
        clear = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        model_count = 0;
        check("clear_wins", count, 0);
        hit(2, 2, 2);
        check("after_clear_hit", count, 1);
        set_rec(0);
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
